flex_fifo_wptr_full: RTL
========================

// Module: flex_fifo_wptr_full
// PURPOSE
//  Write-side pointer and full-flag stage of the JTAG async FIFO. Counts accepted writes in binary and
//  produces the RAM write address. Drives a registered Gray-coded write pointer for the read domain.
//  Synchronizes the read domain's Gray pointer into this clock, converts it to binary, and derives
//  full, almost_full, fill level and overflow. The read pointer feeds this block through the
//  binary/Gray conversion stage.
// PARAMETERS
//  ADDR_WIDTH         4   FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; legal >= 2
//  ALMOST_FULL_LEVEL  12  almost_full asserts when level >= this; legal 1..2**ADDR_WIDTH
// PORTS
//  clk              in   1             write-domain clock, rising edge
//  n_rst            in   1             reset, synchronous, active-low
//  wen              in   1             write request
//  rptr_gray_async  in   ADDR_WIDTH+1  read-domain Gray pointer; asynchronous to clk
//  waddr            out  ADDR_WIDTH    RAM write address = wbin[ADDR_WIDTH-1:0]
//  wptr_gray        out  ADDR_WIDTH+1  registered Gray write pointer, sent to read domain
//  wr_accept        out  1             comb: wen & ~full; RAM write enable
//  full             out  1             registered full flag
//  almost_full      out  1             registered; level >= ALMOST_FULL_LEVEL
//  wlevel           out  ADDR_WIDTH+1  registered fill level, range 0..2**ADDR_WIDTH
//  overflow         out  1             registered 1-cycle pulse: wen seen while full
// BEHAVIOUR
//  - Reset: when n_rst=0 at a rising clk edge, all registers clear to 0 (wbin, wptr_gray, rsync1,
//    rsync2, full, almost_full, wlevel, overflow). Low n_rst without a clk edge has no effect.
//    Reset mid-operation aborts the in-flight write, and the next edge loads zeros.
//  - Synchronizer: rsync1 <= rptr_gray_async; rsync2 <= rsync1. No other logic touches rsync1.
//  - rbin_s = gray2bin(rsync2): bit[ADDR_WIDTH] = g[ADDR_WIDTH]; bit[i] = bit[i+1] ^ g[i].
//  - wbin_next = wbin + wr_accept, modulo 2**(ADDR_WIDTH+1). wrap 2**(ADDR_WIDTH+1)-1 -> 0.
//    wgray_next = wbin_next ^ (wbin_next >> 1).
//  - Every edge (n_rst=1):
//    - wbin <= wbin_next; wptr_gray <= wgray_next.
//    - full <= (wgray_next == {~rsync2[AW:AW-1], rsync2[AW-2:0]}).
//    - wlevel <= wbin_next - rbin_s, (ADDR_WIDTH+1)-bit modulo subtraction.
//    - almost_full <= ((wbin_next - rbin_s) >= ALMOST_FULL_LEVEL).
//    - overflow <= wen & full.
//  - Writes while full are dropped: wr_accept=0, pointers hold, and overflow pulses on the next cycle.
//  - Latency:
//    - Accepted write: waddr and wptr_gray update at the same edge that writes the RAM.
//    - full asserts at the edge accepting the last free slot.
//    - A read-pointer change reaches full, wlevel and almost_full at the 3rd clk edge after it is stable.
//  - full is pessimistic: it deasserts only after the synchronized read pointer advances.
//    Never overwrite unread data.
//  - wptr_gray changes by at most 1 bit per cycle (Gray guarantee for the CDC path).
//  - Simultaneous wen and read-pointer update: write is judged against the current full.
//    The new rsync2 is used from the following cycle.
// TESTING (ADDR_WIDTH=2, ALMOST_FULL_LEVEL=3, rptr_gray_async=000 unless stated)
//  1. Reset: n_rst=0 for 1 edge with wen=1 -> waddr=0, wptr_gray=000, full=0, almost_full=0,
//     wlevel=0, overflow=0.
//  2. 4 consecutive wen=1 -> waddr 0,1,2,3; wptr_gray 001,011,010,110.
//     almost_full rises with 3rd accept, full rises with 4th; wlevel=4.
//  3. wen=1 for 2 cycles while full -> wr_accept=0, wptr_gray stays 110, overflow=1 one cycle after each.
//  4. While full, set rptr_gray_async=001 -> full=0 and wlevel=3 after the 3rd edge; almost_full stays 1.
//  5. Wrap: 8 writes with rptr_gray_async set 2 cycles behind -> wptr_gray returns to 000,
//     waddr wraps 3->0, full never asserts.
//  6. Reset mid-burst: n_rst=0 at an edge after 2 writes -> all outputs 0 next cycle.
//     The following write uses waddr=0.

Source files
------------

// File: rtl/flex_fifo_wptr_full.sv
// rtl/flex_fifo_wptr_full.sv - write-side pointer, Gray export, read-pointer sync and full/level flags
module flex_fifo_wptr_full #(
   parameter int ADDR_WIDTH        = 4,
   parameter int ALMOST_FULL_LEVEL = 12
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  wen,
   input  logic [ADDR_WIDTH:0]   rptr_gray_async,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [ADDR_WIDTH:0]   wptr_gray,
   output logic                  wr_accept,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  overflow
);

   localparam int AW = ADDR_WIDTH;
   localparam logic [AW:0] AF_LEVEL = (AW+1)'(ALMOST_FULL_LEVEL);

   logic [AW:0] wbin_q, wbin_d;
   logic [AW:0] wptr_gray_q, wgray_d;
   logic [AW:0] rsync1_q, rsync2_q;
   logic [AW:0] rbin_s;
   logic [AW:0] wlevel_q, wlevel_d;
   logic [AW:0] full_cmp;
   logic        full_q, full_d;
   logic        almost_full_q, almost_full_d;
   logic        overflow_q, overflow_d;

   // Each binary bit is the XOR of all Gray bits at or above it.
   genvar gi;
   generate
      for (gi = 0; gi <= AW; gi++) begin : g_gray2bin
         assign rbin_s[gi] = ^rsync2_q[AW:gi];
      end
   endgenerate

   // A write is only committed when the FIFO is not already flagged full.
   assign wr_accept = wen & ~full_q;

   // Next-state pointers, flags and level from the post-write pointer and the synced read pointer.
   always_comb begin
      wbin_d        = wbin_q + {{AW{1'b0}}, wr_accept};
      wgray_d       = wbin_d ^ (wbin_d >> 1);
      // Full when write pointer is one lap ahead: top two Gray bits inverted, rest equal.
      full_cmp      = {~rsync2_q[AW:AW-1], rsync2_q[AW-2:0]};
      full_d        = (wgray_d == full_cmp);
      wlevel_d      = wbin_d - rbin_s;
      almost_full_d = (wlevel_d >= AF_LEVEL);
      overflow_d    = wen & full_q;
   end

   // Register pointers, two-flop read-pointer synchronizer and status flags.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wbin_q        <= '0;
         wptr_gray_q   <= '0;
         rsync1_q      <= '0;
         rsync2_q      <= '0;
         full_q        <= 1'b0;
         almost_full_q <= 1'b0;
         wlevel_q      <= '0;
         overflow_q    <= 1'b0;
      end else begin
         wbin_q        <= wbin_d;
         wptr_gray_q   <= wgray_d;
         rsync1_q      <= rptr_gray_async;
         rsync2_q      <= rsync1_q;
         full_q        <= full_d;
         almost_full_q <= almost_full_d;
         wlevel_q      <= wlevel_d;
         overflow_q    <= overflow_d;
      end
   end

   assign waddr       = wbin_q[AW-1:0];
   assign wptr_gray   = wptr_gray_q;
   assign full        = full_q;
   assign almost_full = almost_full_q;
   assign wlevel      = wlevel_q;
   assign overflow    = overflow_q;

endmodule
